posit_accumulate_es3: RTL and testbench
=======================================

# posit_accumulate_es3

Streaming reduction front-end for the 32-bit ES=3 posit adder pipeline. Accepts a valid/ready stream of posits terminated by `in_last`, drives the adder's `start/in1/in2` port one operation at a time with the running sum fed back as `in1`, and collects `result/inf/zero/done`. After the final element it presents the reduced sum on a valid/ready output. It is the initiator and consumer side of the adder's start/done protocol.

## Interface
- `NBITS`, 32: posit width; fixed to match the adder.
- `CNT_W`, 16: width of the element counter.
- `TIMEOUT`, 64: maximum cycles in BUSY waiting for `add_done` before the error path fires.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input element valid.
- `in_ready`  out  1  block can accept an element.
- `in_data`  in  32  posit operand.
- `in_last`  in  1  marks the final element of the current reduction.
- `add_start`  out  1  one-cycle start pulse to the adder.
- `add_in1`  out  32  accumulator value; registered.
- `add_in2`  out  32  captured element; registered.
- `add_result`  in  32  adder sum.
- `add_inf`  in  1  adder NaR flag.
- `add_zero`  in  1  adder zero flag.
- `add_done`  in  1  adder result valid (single-cycle).
- `out_valid`  out  1  reduction result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  32  reduced posit sum.
- `out_inf`  out  1  `out_data` equals NaR (32'h80000000).
- `out_zero`  out  1  `out_data` equals 32'h00000000.
- `out_count`  out  CNT_W  number of elements summed; saturates at all-ones.
- `out_err`  out  1  reduction aborted by the timeout.

## Operation
- States:
  - ACCEPT: `in_ready`=1.
  - BUSY: waiting for the adder.
  - OUT: `out_valid`=1.
- Reset:
  - State goes to ACCEPT.
  - acc=0, count=0, err=0.
  - `add_start`=0, `add_in1`/`add_in2`=0, `out_valid`=0.
- ACCEPT, on `in_valid && in_ready`:
  - Register `add_in1`<=acc, `add_in2`<=`in_data`, last_q<=`in_last`.
  - Assert `add_start` for exactly the next cycle.
  - Go to BUSY.
- BUSY, on `add_done`:
  - acc<=`add_result`; count<=count+1 (saturating).
  - Go to OUT if last_q, else ACCEPT.
- `add_in1`/`add_in2` stay stable from the start pulse until BUSY exits.
- Timeout in BUSY: if the wait counter reaches `TIMEOUT` with no `add_done`, then acc<=32'h80000000, err<=1, and the state goes to OUT regardless of last_q.
  - Any remaining input elements of the aborted reduction are accepted as a new reduction.
- OUT:
  - `out_data`=acc; `out_inf`/`out_zero` decoded from acc.
  - `out_count`=count; `out_err`=err.
  - All outputs are held while `out_ready`=0.
  - On `out_ready`: acc<=0, count<=0, err<=0, go to ACCEPT.
- `add_done` outside BUSY (a stray done, e.g. after reset or timeout) is ignored and changes no state.
- NaR propagates through the adder, so a NaR element yields `out_inf`=1; the block performs no extra NaR handling.
- `add_inf`/`add_zero` are not stored; the output flags are decoded from acc.

## Timing
- Element accepted at edge E.
- `add_start` is high in cycle E+1.
- The adder latency is 8 cycles, so `add_done` is high in cycle E+9; acc updates at the end of E+9.
- `in_ready` is high again in cycle E+10, giving a throughput of 1 element per 10 cycles.
- Last element accepted at edge E: `out_valid` is high from cycle E+10.
- A reduction of N elements gives first `out_valid` 10·N cycles after the first accept, assuming `in_valid` is continuously high.
- `in_ready` and `out_valid` are never high together.
- Reset asserted mid-BUSY clears all state immediately (asynchronous). The later `add_done` arrives in ACCEPT and is ignored.

## Test plan
- Sum {0x40000000 (1.0), 0x44000000 (2.0, last)}:
  - `out_data`=0x46000000 (3.0), `out_count`=2, `out_zero`=0, `out_err`=0.
  - `out_valid` is first seen 20 cycles after the first accept.
- Single element 0x40000000 with last:
  - `out_data`=0x40000000, `out_count`=1.
  - `add_in1` is 0 during the start pulse.
- Sum {0x40000000, 0xC0000000 (-1.0, last)}:
  - `out_data`=0, `out_zero`=1.
- Sum {0x40000000, 0x80000000, 0x44000000 (last)}:
  - `out_data`=0x80000000, `out_inf`=1, `out_count`=3.
- Hold `out_ready`=0 for 5 cycles in OUT:
  - Outputs stay stable and `in_ready` stays 0.
  - On `out_ready`=1 the next cycle shows `in_ready`=1, and the next reduction starts from acc=0.
- Adder model never asserts done:
  - After `TIMEOUT` cycles, `out_data`=0x80000000 and `out_err`=1.
- Separately, assert reset during BUSY and then inject a stray `add_done`:
  - acc stays 0 and the state stays ACCEPT.

Source files
------------

// File: rtl/posit_accumulate_es3.sv
// Streaming reduction front-end for the 32-bit ES=3 posit adder: feeds the running
// sum back through the adder one element at a time and presents the final sum.
module posit_accumulate_es3 #(
  parameter int NBITS   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_last,
  output logic             add_start,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_inf,
  input  logic             add_zero,
  input  logic             add_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_OUT    = 2'd2;

  localparam logic [NBITS-1:0] NAR  = {1'b1, {(NBITS-1){1'b0}}};
  localparam int               TO_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state;
  logic [NBITS-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             err;
  logic             last_q;
  logic [TO_W-1:0]  wait_cnt;
  logic             timeout_hit;
  logic             unused_flags;

  // The adder's own flags are redundant: output flags are decoded from acc.
  assign unused_flags = add_inf ^ add_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign timeout_hit = (wait_cnt == TO_W'(TIMEOUT - 1));

  assign in_ready  = (state == S_ACCEPT);
  assign out_valid = (state == S_OUT);
  assign out_data  = acc;
  assign out_inf   = (acc == NAR);
  assign out_zero  = (acc == '0);
  assign out_count = count;
  assign out_err   = err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_ACCEPT;
      acc       <= '0;
      count     <= '0;
      err       <= 1'b0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      add_start <= 1'b0;
      add_in1   <= '0;
      add_in2   <= '0;
    end else begin
      add_start <= 1'b0;
      case (state)
        S_ACCEPT: begin
          if (in_valid) begin
            add_in1   <= acc;
            add_in2   <= in_data;
            last_q    <= in_last;
            add_start <= 1'b1;
            wait_cnt  <= '0;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Operands stay frozen here; only done or the timeout leaves BUSY.
          if (add_done) begin
            acc   <= add_result;
            count <= sat_inc(count);
            state <= last_q ? S_OUT : S_ACCEPT;
          end else if (timeout_hit) begin
            acc   <= NAR;
            err   <= 1'b1;
            state <= S_OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
            state <= S_ACCEPT;
          end
        end
        default: state <= S_ACCEPT;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_accumulate_es3.sv
// Bench for posit_accumulate_es3: an 8-cycle adder stand-in plus a reduction-level
// reference model working on integer-valued posits.
module tb_posit_accumulate_es3;

  localparam int TIMEOUT = 64;
  localparam logic [31:0] NAR = 32'h80000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        add_start;
  logic [31:0] add_in1, add_in2;
  logic [31:0] add_result;
  logic        add_inf, add_zero, add_done;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_inf, out_zero, out_err;
  logic [15:0] out_count;

  posit_accumulate_es3 #(.NBITS(32), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inf(out_inf), .out_zero(out_zero), .out_count(out_count), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Integer <-> posit(32,3) for |v| < 256 (regime k=0, exponent = floor(log2 |v|)).
  function automatic logic [31:0] enc(input int v);
    int a, e;
    logic [25:0] f;
    logic [31:0] p;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 8; i++) if (a >= (1 << i)) e = i;
    f = 26'((a - (1 << e)) << (26 - e));
    p = {1'b0, 2'b10, 3'(e), f};
    return (v < 0) ? -p : p;
  endfunction

  function automatic int dec(input logic [31:0] p);
    logic [31:0] a, m;
    int e;
    if (p == 32'h0) return 0;
    a = p[31] ? -p : p;
    e = int'(a[28:26]);
    m = {5'b0, 1'b1, a[25:0]};
    return p[31] ? -int'(m >> (26 - e)) : int'(m >> (26 - e));
  endfunction

  function automatic logic [31:0] padd(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    return enc(dec(a) + dec(b));
  endfunction

  // Adder stand-in: done exactly 8 cycles after the start cycle.
  bit          stub_en = 1'b1;
  bit          stray_req = 1'b0;
  bit          hold_ok = 1'b0;
  int          pend = 0;
  logic [31:0] a1, a2, start_in1;

  initial begin
    add_done = 1'b0; add_result = '0; add_inf = 1'b0; add_zero = 1'b0;
    forever begin
      @(negedge clk);
      add_done = 1'b0;
      if (!reset_n) hold_ok = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && stub_en) begin
          add_done   = 1'b1;
          add_result = padd(a1, a2);
          add_inf    = (add_result == NAR);
          add_zero   = (add_result == 32'h0);
          if (hold_ok) begin
            check("in1_hold", add_in1, a1);
            check("in2_hold", add_in2, a2);
          end
        end
      end
      if (stray_req) begin
        add_done   = 1'b1;
        add_result = 32'h48000000;
        stray_req  = 1'b0;
      end
      if (add_start === 1'b1) begin
        check("start_idle", pend, 0);
        a1 = add_in1; a2 = add_in2; start_in1 = add_in1;
        pend = 8; hold_ok = 1'b1;
      end
    end
  end

  logic [31:0] elems[$];

  task automatic run_red(input int hold, input bit to_mode);
    int c0, lat, sum;
    bit nar;
    logic [31:0] exp_d, snap_d, snap_m;
    sum = 0; nar = 1'b0;
    foreach (elems[i]) begin
      if (elems[i] == NAR) nar = 1'b1;
      else sum += dec(elems[i]);
    end
    exp_d = to_mode ? NAR : (nar ? NAR : enc(sum));
    c0 = 0;
    foreach (elems[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = elems[i];
      in_last  = to_mode ? 1'b0 : (i == elems.size() - 1);
      for (int k = 0; k < 300 && !in_ready; k++) @(negedge clk);
      if (!in_ready) begin
        check("accept_wait", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) c0 = cyc;
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int k = 0; k < 400 && !out_valid; k++) @(negedge clk);
    if (!out_valid) begin
      check("out_wait", out_valid, 1);
      return;
    end
    lat = cyc - c0;
    if (to_mode) check("to_window", (lat >= TIMEOUT && lat <= TIMEOUT + 3), 1);
    else check("latency", lat, 10 * elems.size());
    check("data", out_data, exp_d);
    check("inf", out_inf, exp_d == NAR);
    check("zero", out_zero, exp_d == 32'h0);
    check("count", out_count, to_mode ? 0 : elems.size());
    check("err", out_err, to_mode);
    check("ready_in_out", in_ready, 0);
    snap_d = out_data;
    snap_m = {out_count, out_inf, out_zero, out_err};
    repeat (hold) begin
      @(negedge clk);
      check("hold_data", out_data, snap_d);
      check("hold_meta", {out_count, out_inf, out_zero, out_err}, snap_m);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_ready", in_ready, 1);
    check("release_valid", out_valid, 0);
    check("release_acc", out_data, 0);
    check("release_cnt", out_count, 0);
  endtask

  bit seen_valid;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_start", add_start, 0);
    check("rst_in1", add_in1, 0);
    check("rst_in2", add_in2, 0);
    check("rst_acc", out_data, 0);
    check("rst_cnt", out_count, 0);
    check("rst_err", out_err, 0);
    reset_n = 1'b1;
    @(negedge clk);

    elems = '{32'h40000000, 32'h44000000};
    run_red(0, 0);
    elems = '{32'h40000000};
    run_red(0, 0);
    check("single_in1", start_in1, 0);
    elems = '{32'h40000000, 32'hC0000000};
    run_red(0, 0);
    elems = '{32'h40000000, NAR, 32'h44000000};
    run_red(0, 0);
    elems = '{32'h44000000, 32'h46000000};
    run_red(5, 0);
    check("fresh_in1", start_in1, 32'h44000000);

    stub_en = 1'b0;
    elems = '{32'h40000000};
    run_red(1, 1);
    stub_en = 1'b1;
    elems = '{32'h44000000};
    run_red(0, 0);
    check("post_to_in1", start_in1, 0);

    // Reset in the middle of BUSY; the adder's done then lands in ACCEPT.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h44000000; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_in2", add_in2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    stray_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    check("stray_valid", seen_valid, 0);
    check("stray_acc", out_data, 0);
    check("stray_cnt", out_count, 0);
    check("stray_ready", in_ready, 1);
    elems = '{32'h40000000};
    run_red(0, 0);
    check("after_rst_in1", start_in1, 0);

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 4);
      elems = {};
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 9) == 0) elems.push_back(NAR);
        else elems.push_back(enc(int'($urandom_range(0, 40)) - 20));
      end
      run_red($urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
